// File: rtl/program_counter_stack.sv
// program_counter_stack
//
// Program counter with a PCLATH latch and a circular hardware return stack.
// It takes one-cycle strobes from the instruction decoder and PCL/PCLATH
// writes from the ALU result bus. It drives the fetch address to program
// memory.
//
// Strobes are single-cycle pulses with no handshake. Each strobe is sampled
// on a rising clk edge, and its effect is visible on the outputs after that
// edge. Every output comes straight from a register, so no input reaches an
// output combinationally.
//
// Ports:
//   clk               system clock; all state changes on the rising edge
//   rst               asynchronous, active-low reset
//   pc_incr_en        PC <= PC + 1
//   pc_j_en           goto:   PC <= {PCLATH upper bits, pc_j_addr}
//   pc_j_and_push_en  call:   push PC, then goto
//   pc_j_by_pop_en    return: PC <= popped entry
//   int_vector_en     interrupt entry: push PC, then PC <= INT_VECTOR
//   pc_j_addr         goto/call literal
//   pcl_wr_en         computed jump: PC <= {PCLATH, pcl_in}
//   pcl_in            new PCL value
//   pclath_wr_en      PCLATH <= pclath_in (independent of the PC strobes)
//   pclath_in         new PCLATH value
//   stack_flags_clr   clears the sticky overflow/underflow flags
//   pc_out            current PC
//   pclath_out        PCLATH register
//   stack_count       number of valid stack entries (saturating)
//   stack_overflow    sticky: a push happened while the stack was full
//   stack_underflow   sticky: a pop happened while the stack was empty
module program_counter_stack #(
    parameter int PC_WIDTH     = 13,
    parameter int JUMP_WIDTH   = 11,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0,
    parameter int INT_VECTOR   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pc_incr_en,
    input  logic                           pc_j_en,
    input  logic                           pc_j_and_push_en,
    input  logic                           pc_j_by_pop_en,
    input  logic                           int_vector_en,
    input  logic [JUMP_WIDTH-1:0]          pc_j_addr,
    input  logic                           pcl_wr_en,
    input  logic [7:0]                     pcl_in,
    input  logic                           pclath_wr_en,
    input  logic [PC_WIDTH-9:0]            pclath_in,
    input  logic                           stack_flags_clr,
    output logic [PC_WIDTH-1:0]            pc_out,
    output logic [PC_WIDTH-9:0]            pclath_out,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-9:0] pclath_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic                unf_q;
    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic                do_push;
    logic                do_pop;
    logic                stack_full;
    logic                stack_empty;
    logic [PTR_W-1:0]    pop_ptr;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] pc_next;

    // A push comes from an interrupt, or from a call that no higher strobe
    // overrides. A return only pops when no interrupt is present.
    assign do_push     = int_vector_en | (pc_j_and_push_en & ~pc_j_by_pop_en);
    assign do_pop      = pc_j_by_pop_en & ~int_vector_en;
    assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign stack_empty = (cnt_q == '0);
    // STACK_DEPTH is a power of two, so the pointer arithmetic wraps by itself.
    assign pop_ptr     = ptr_q - PTR_W'(1);

    // The literal supplies the low JUMP_WIDTH bits. PCLATH supplies the bits
    // above it. Overlaying the literal on {PCLATH, 8'h00} keeps that correct
    // for any JUMP_WIDTH up to PC_WIDTH.
    always_comb begin
        jump_target                   = {pclath_q, 8'h00};
        jump_target[JUMP_WIDTH-1:0]   = pc_j_addr;
    end

    always_comb begin
        pc_next = pc_q;
        if (int_vector_en)
            pc_next = PC_WIDTH'(INT_VECTOR);
        else if (pc_j_by_pop_en)
            pc_next = stack_mem[pop_ptr];
        else if (pc_j_and_push_en || pc_j_en)
            pc_next = jump_target;
        else if (pcl_wr_en)
            pc_next = {pclath_q, pcl_in};
        else if (pc_incr_en)
            pc_next = pc_q + PC_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= PC_WIDTH'(RESET_VECTOR);
            pclath_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++)
                stack_mem[i] <= '0;
        end else begin
            pc_q <= pc_next;

            if (pclath_wr_en)
                pclath_q <= pclath_in;

            // A push when full overwrites the oldest entry, because the write
            // slot after a full wrap is that entry's slot.
            if (do_push) begin
                stack_mem[ptr_q] <= pc_q;
                ptr_q            <= ptr_q + PTR_W'(1);
                if (!stack_full)
                    cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop) begin
                ptr_q <= pop_ptr;
                if (!stack_empty)
                    cnt_q <= cnt_q - CNT_W'(1);
            end

            // Set takes priority over clear when both happen in one cycle.
            if (do_push && stack_full)
                ovf_q <= 1'b1;
            else if (stack_flags_clr)
                ovf_q <= 1'b0;

            if (do_pop && stack_empty)
                unf_q <= 1'b1;
            else if (stack_flags_clr)
                unf_q <= 1'b0;
        end
    end

    assign pc_out          = pc_q;
    assign pclath_out      = pclath_q;
    assign stack_count     = cnt_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack at its default parameters.
// Each step is one cycle of strobes with the state expected after the edge.
// The expected state goes onto exp_q when the stimulus is driven. It is
// popped and compared once the DUT has taken the edge.
module tb_program_counter_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_incr_en = 1'b0;
    logic        pc_j_en = 1'b0;
    logic        pc_j_and_push_en = 1'b0;
    logic        pc_j_by_pop_en = 1'b0;
    logic        int_vector_en = 1'b0;
    logic [10:0] pc_j_addr = '0;
    logic        pcl_wr_en = 1'b0;
    logic [7:0]  pcl_in = '0;
    logic        pclath_wr_en = 1'b0;
    logic [4:0]  pclath_in = '0;
    logic        stack_flags_clr = 1'b0;
    logic [12:0] pc_out;
    logic [4:0]  pclath_out;
    logic [3:0]  stack_count;
    logic        stack_overflow;
    logic        stack_underflow;

    program_counter_stack dut (
        .clk              (clk),
        .rst              (rst),
        .pc_incr_en       (pc_incr_en),
        .pc_j_en          (pc_j_en),
        .pc_j_and_push_en (pc_j_and_push_en),
        .pc_j_by_pop_en   (pc_j_by_pop_en),
        .int_vector_en    (int_vector_en),
        .pc_j_addr        (pc_j_addr),
        .pcl_wr_en        (pcl_wr_en),
        .pcl_in           (pcl_in),
        .pclath_wr_en     (pclath_wr_en),
        .pclath_in        (pclath_in),
        .stack_flags_clr  (stack_flags_clr),
        .pc_out           (pc_out),
        .pclath_out       (pclath_out),
        .stack_count      (stack_count),
        .stack_overflow   (stack_overflow),
        .stack_underflow  (stack_underflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic        incr, j, call, ret, intv;
        logic [10:0] addr;
        logic        pclw;
        logic [7:0]  pcl;
        logic        plw;
        logic [4:0]  plin;
        logic        clr;
        logic [12:0] e_pc;
        logic [4:0]  e_pclath;
        logic [3:0]  e_cnt;
        logic        e_ov, e_un;
    } vec_t;

    localparam int W = 24;   // {pc, pclath, count, ov, un}
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(
        input logic incr, input logic j, input logic call, input logic ret, input logic intv,
        input logic [10:0] addr, input logic pclw, input logic [7:0] pcl,
        input logic plw, input logic [4:0] plin, input logic clr,
        input logic [12:0] e_pc, input logic [4:0] e_pclath, input logic [3:0] e_cnt,
        input logic e_ov, input logic e_un);
        vec_t v;
        v.incr = incr; v.j = j; v.call = call; v.ret = ret; v.intv = intv;
        v.addr = addr; v.pclw = pclw; v.pcl = pcl; v.plw = plw; v.plin = plin; v.clr = clr;
        v.e_pc = e_pc; v.e_pclath = e_pclath; v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_un = e_un;
        return v;
    endfunction

    function automatic logic [W-1:0] observed();
        return {pc_out, pclath_out, stack_count, stack_overflow, stack_underflow};
    endfunction

    task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got pc=%h pclath=%h cnt=%0d ov=%b un=%b, want pc=%h pclath=%h cnt=%0d ov=%b un=%b",
                     name, got[23:11], got[10:6], got[5:2], got[1], got[0],
                     want[23:11], want[10:6], want[5:2], want[1], want[0]);
        end
    endtask

    task automatic idle_inputs();
        pc_incr_en = 1'b0; pc_j_en = 1'b0; pc_j_and_push_en = 1'b0;
        pc_j_by_pop_en = 1'b0; int_vector_en = 1'b0; pc_j_addr = '0;
        pcl_wr_en = 1'b0; pcl_in = '0; pclath_wr_en = 1'b0; pclath_in = '0;
        stack_flags_clr = 1'b0;
    endtask

    // Drive one cycle of strobes at the falling edge, then check #1 after the rising edge.
    task automatic apply(input vec_t v, input string name);
        logic [W-1:0] want;
        @(negedge clk);
        pc_incr_en = v.incr; pc_j_en = v.j; pc_j_and_push_en = v.call;
        pc_j_by_pop_en = v.ret; int_vector_en = v.intv; pc_j_addr = v.addr;
        pcl_wr_en = v.pclw; pcl_in = v.pcl; pclath_wr_en = v.plw; pclath_in = v.plin;
        stack_flags_clr = v.clr;
        exp_q.push_back({v.e_pc, v.e_pclath, v.e_cnt, v.e_ov, v.e_un});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        compare(name, observed(), want);
    endtask

    // Addresses of the nine calls in the overflow sequence.
    function automatic logic [12:0] a_addr(input int i);
        return 13'h0A0 + 13'(i);
    endfunction

    // ---------------- test ----------------
    initial begin
        vec_t tbl[16];
        //            incr j call ret int addr    pclw pcl   plw plin   clr   pc       pclath cnt ov un
        tbl[0]  = mk(1, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0, 13'h0001, 5'h00, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0, 13'h0002, 5'h00, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0, 13'h0003, 5'h00, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 11'h000, 0, 8'h00, 1, 5'h18, 0, 13'h0003, 5'h18, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 11'h123, 0, 8'h00, 0, 5'h00, 0, 13'h1923, 5'h18, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 11'h000, 0, 8'h00, 1, 5'h00, 0, 13'h1923, 5'h00, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 11'h123, 0, 8'h00, 1, 5'h18, 0, 13'h0123, 5'h18, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 11'h000, 1, 8'h50, 1, 5'h00, 0, 13'h1850, 5'h00, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 11'h000, 1, 8'h50, 0, 5'h00, 0, 13'h0050, 5'h00, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 11'h200, 0, 8'h00, 0, 5'h00, 0, 13'h0200, 5'h00, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0, 13'h0050, 5'h00, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 11'h333, 1, 8'h77, 0, 5'h00, 0, 13'h0333, 5'h00, 0, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 1, 11'h111, 0, 8'h00, 0, 5'h00, 0, 13'h0004, 5'h00, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0, 13'h0333, 5'h00, 0, 0, 0);
        // Pop on an empty stack: slot 7 has never been written, so it returns 0.
        tbl[14] = mk(0, 1, 1, 1, 0, 11'h555, 0, 8'h00, 0, 5'h00, 0, 13'h0000, 5'h00, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 1, 13'h0000, 5'h00, 0, 0, 0);

        // reset block
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare("reset_state", observed(), {13'h0000, 5'h00, 4'd0, 1'b0, 1'b0});

        for (int i = 0; i < 16; i++)
            apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Nine calls from distinct PCs into a depth-8 stack.
        for (int i = 0; i < 9; i++) begin
            apply(mk(0, 0, 0, 0, 0, 11'h000, 1, a_addr(i)[7:0], 0, 5'h00, 0,
                     a_addr(i), 5'h00, 4'((i > 8) ? 8 : i), 0, 0), $sformatf("set_a%0d", i));
            apply(mk(0, 0, 1, 0, 0, 11'h400, 0, 8'h00, 0, 5'h00, 0,
                     13'h0400, 5'h00, 4'((i + 1 > 8) ? 8 : i + 1), (i == 8), 0),
                  $sformatf("call_%0d", i));
        end
        // Eight returns give back A8..A1. The oldest entry, A0, was overwritten.
        for (int k = 0; k < 8; k++)
            apply(mk(0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0,
                     a_addr(8 - k), 5'h00, 4'(7 - k), 1, 0), $sformatf("ret_%0d", k));
        apply(mk(0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0,
                 a_addr(8), 5'h00, 4'd0, 1, 1), "ret_underflow");
        apply(mk(0, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 1,
                 a_addr(8), 5'h00, 4'd0, 0, 0), "clr_both");

        // Fill the stack with interrupt entries. Then clear in the same cycle
        // as a fresh overflow; the flag must stay set.
        for (int k = 0; k < 8; k++)
            apply(mk(0, 0, 0, 0, 1, 11'h000, 0, 8'h00, 0, 5'h00, 0,
                     13'h0004, 5'h00, 4'(k + 1), 0, 0), $sformatf("int_fill_%0d", k));
        apply(mk(0, 0, 0, 0, 1, 11'h000, 0, 8'h00, 0, 5'h00, 1,
                 13'h0004, 5'h00, 4'd8, 1, 0), "clr_vs_overflow");
        apply(mk(0, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 1,
                 13'h0004, 5'h00, 4'd8, 0, 0), "clr_overflow");

        // Increment wraps at the top of the address space.
        apply(mk(0, 0, 0, 0, 0, 11'h000, 0, 8'h00, 1, 5'h1F, 0,
                 13'h0004, 5'h1F, 4'd8, 0, 0), "pclath_1f");
        apply(mk(0, 0, 0, 0, 0, 11'h000, 1, 8'hFF, 0, 5'h00, 0,
                 13'h1FFF, 5'h1F, 4'd8, 0, 0), "pc_1fff");
        apply(mk(1, 0, 0, 0, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0,
                 13'h0000, 5'h1F, 4'd8, 0, 0), "incr_wrap");
        apply(mk(0, 1, 0, 0, 0, 11'h321, 0, 8'h00, 0, 5'h00, 0,
                 13'h1B21, 5'h1F, 4'd8, 0, 0), "goto_1b21");

        // Reset pulled low mid-cycle while a call is pending. The outputs
        // must clear before any clock edge arrives.
        @(negedge clk);
        pc_j_and_push_en = 1'b1;
        pc_j_addr = 11'h123;
        #2;
        rst = 1'b0;
        #1;
        compare("async_reset", observed(), {13'h0000, 5'h00, 4'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        compare("reset_hold", observed(), {13'h0000, 5'h00, 4'd0, 1'b0, 1'b0});
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        // Stack entries were cleared too, so an empty pop returns 0.
        apply(mk(0, 0, 0, 1, 0, 11'h000, 0, 8'h00, 0, 5'h00, 0,
                 13'h0000, 5'h00, 4'd0, 0, 1), "pop_after_reset");

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
